uart_host_ctrl: RTL and testbench

UART_HOST_CTRL -- requirements
Module: uart_host_ctrl

---
 rtl/uart_host_ctrl_if.sv | 47 ++++
 rtl/uart_host_ctrl.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_uart_host_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_host_ctrl_if
// Wishbone classic bus bundle between the UART host controller (master) and
// the 8250-style UART register file (slave).
//
// Signals:
//   ADR_O  [31:0]  byte address of the UART register being accessed
//   DAT_O  [31:0]  write data, byte in [7:0], upper bits zero
//   DAT_I  [31:0]  read data, only [7:0] is meaningful
//   WE_O           1 = write, 0 = read
//   SEL_O  [3:0]   byte lane select, 4'b0001 during a strobe, else 0
//   STB_O          strobe
//   CYC_O          bus cycle
//   ACK_I          slave acknowledge
// ---------------------------------------------------------------------------
interface uart_host_ctrl_if;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        WE_O;
    logic [3:0]  SEL_O;
    logic        STB_O;
    logic        CYC_O;
    logic        ACK_I;

    modport master (
        output ADR_O,
        output DAT_O,
        output WE_O,
        output SEL_O,
        output STB_O,
        output CYC_O,
        input  DAT_I,
        input  ACK_I
    );

    modport slave (
        input  ADR_O,
        input  DAT_O,
        input  WE_O,
        input  SEL_O,
        input  STB_O,
        input  CYC_O,
        output DAT_I,
        output ACK_I
    );
endinterface

// File: rtl/uart_host_ctrl.sv
// ---------------------------------------------------------------------------
// uart_host_ctrl
// Wishbone master that initialises an 8250 UART (baud divisor, line control,
// FIFO, interrupt and modem control) and then polls the line status register
// to move bytes between a one-entry user TX buffer and a one-entry user RX
// holding register.
//
// Ports:
//   CLK_I       clock, all state changes on the rising edge
//   RST_I       asynchronous active-low reset
//   wb          Wishbone master bundle (uart_host_ctrl_if.master)
//   tx_valid    user offers tx_data
//   tx_data     byte to transmit
//   tx_ready    controller accepts tx_data this cycle
//   rx_valid    received byte available on rx_data
//   rx_data     received byte
//   rx_ready    user consumes rx_data
//   init_done   UART initialisation sequence finished
//   bus_err     sticky flag, some bus transaction timed out
// ---------------------------------------------------------------------------
module uart_host_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h1250_0000,
    parameter logic [15:0] DIVISOR   = 16'd27,
    parameter logic [7:0]  LCR_VAL   = 8'h03,
    parameter logic [7:0]  TIMEOUT   = 8'd64
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    uart_host_ctrl_if.master        wb,
    input  logic                    tx_valid,
    input  logic [7:0]              tx_data,
    output logic                    tx_ready,
    output logic                    rx_valid,
    output logic [7:0]              rx_data,
    input  logic                    rx_ready,
    output logic                    init_done,
    output logic                    bus_err
);

    typedef enum logic [1:0] {
        INIT,
        POLL,
        WR_THR,
        RD_RHR
    } state_t;

    localparam logic [2:0] OFS_DATA = 3'd0;
    localparam logic [2:0] OFS_IER  = 3'd1;
    localparam logic [2:0] OFS_FCR  = 3'd2;
    localparam logic [2:0] OFS_LCR  = 3'd3;
    localparam logic [2:0] OFS_MCR  = 3'd4;
    localparam logic [2:0] OFS_LSR  = 3'd5;

    state_t      r_state;
    logic [2:0]  r_initStep;
    logic        r_stb;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [7:0]  r_dat;
    logic [7:0]  r_waitCnt;
    logic        r_txFull;
    logic [7:0]  r_txData;
    logic        r_rxValid;
    logic [7:0]  r_rxData;
    logic        r_initDone;
    logic        r_busErr;

    state_t      w_nextState;
    logic [2:0]  w_nextInitStep;
    logic        w_ack;
    logic        w_timeout;
    logic        w_done;
    logic        w_issue;
    logic [7:0]  w_rdByte;
    logic [2:0]  w_offset;
    logic        w_issueWe;
    logic [7:0]  w_issueDat;
    logic [31:0] w_issueAdr;
    logic        w_txClear;
    logic        w_rxLoad;
    logic        w_txReady;

    // A transaction finishes either on a real acknowledge or when the wait
    // counter has seen TIMEOUT strobe cycles without one. A timed-out read
    // behaves as if the slave returned zero, so the FSM never stalls.
    assign w_ack      = r_stb & wb.ACK_I;
    assign w_timeout  = r_stb & ~wb.ACK_I & (r_waitCnt == (TIMEOUT - 8'd1));
    assign w_done     = w_ack | w_timeout;
    assign w_rdByte   = w_ack ? wb.DAT_I[7:0] : 8'h00;
    assign w_issue    = ~r_stb;
    assign w_issueAdr = BASE_ADDR + {29'd0, w_offset};
    assign w_txReady  = r_initDone & ~r_txFull;

    assign wb.CYC_O   = r_stb;
    assign wb.STB_O   = r_stb;
    assign wb.WE_O    = r_we;
    assign wb.SEL_O   = r_sel;
    assign wb.ADR_O   = r_adr;
    assign wb.DAT_O   = {24'h000000, r_dat};

    assign tx_ready   = w_txReady;
    assign rx_valid   = r_rxValid;
    assign rx_data    = r_rxData;
    assign init_done  = r_initDone;
    assign bus_err    = r_busErr;

    // State register for the controller FSM plus the index into the
    // seven-write initialisation sequence.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state    <= INIT;
            r_initStep <= 3'd0;
        end else begin
            r_state    <= w_nextState;
            r_initStep <= w_nextInitStep;
        end
    end

    // Next-state logic. Each state describes the single transaction it wants
    // on the bus; the state only advances when that transaction is done.
    // In POLL the freshly read LSR decides where to go, with TX taking
    // priority over RX when both the THR-empty and data-ready bits are set.
    always_comb begin
        w_nextState    = r_state;
        w_nextInitStep = r_initStep;
        w_offset       = OFS_LSR;
        w_issueWe      = 1'b0;
        w_issueDat     = 8'h00;
        w_txClear      = 1'b0;
        w_rxLoad       = 1'b0;
        case (r_state)
            INIT: begin
                w_issueWe = 1'b1;
                case (r_initStep)
                    3'd0: begin
                        w_offset   = OFS_LCR;
                        w_issueDat = 8'h80 | LCR_VAL;
                    end
                    3'd1: begin
                        w_offset   = OFS_DATA;
                        w_issueDat = DIVISOR[7:0];
                    end
                    3'd2: begin
                        w_offset   = OFS_IER;
                        w_issueDat = DIVISOR[15:8];
                    end
                    3'd3: begin
                        w_offset   = OFS_LCR;
                        w_issueDat = LCR_VAL;
                    end
                    3'd4: begin
                        w_offset   = OFS_FCR;
                        w_issueDat = 8'h07;
                    end
                    3'd5: begin
                        w_offset   = OFS_IER;
                        w_issueDat = 8'h00;
                    end
                    default: begin
                        w_offset   = OFS_MCR;
                        w_issueDat = 8'h03;
                    end
                endcase
                if (w_done) begin
                    if (r_initStep == 3'd6) begin
                        w_nextState    = POLL;
                        w_nextInitStep = 3'd0;
                    end else begin
                        w_nextInitStep = r_initStep + 3'd1;
                    end
                end
            end
            POLL: begin
                w_offset = OFS_LSR;
                if (w_done) begin
                    if (w_rdByte[5] && r_txFull) begin
                        w_nextState = WR_THR;
                    end else if (w_rdByte[0] && !r_rxValid) begin
                        w_nextState = RD_RHR;
                    end else begin
                        w_nextState = POLL;
                    end
                end
            end
            WR_THR: begin
                w_offset   = OFS_DATA;
                w_issueWe  = 1'b1;
                w_issueDat = r_txData;
                if (w_done) begin
                    w_txClear   = 1'b1;
                    w_nextState = POLL;
                end
            end
            RD_RHR: begin
                w_offset = OFS_DATA;
                if (w_done) begin
                    w_rxLoad    = 1'b1;
                    w_nextState = POLL;
                end
            end
            default: begin
                w_nextState    = INIT;
                w_nextInitStep = 3'd0;
            end
        endcase
    end

    // Bus output registers. A new transaction is launched whenever the bus
    // is idle, and completion drops everything back to zero; because launch
    // and completion never share an edge, there is always at least one idle
    // cycle between transactions.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= 4'b0000;
            r_adr <= 32'h0000_0000;
            r_dat <= 8'h00;
        end else if (w_done) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= 4'b0000;
            r_adr <= 32'h0000_0000;
            r_dat <= 8'h00;
        end else if (w_issue) begin
            r_stb <= 1'b1;
            r_we  <= w_issueWe;
            r_sel <= 4'b0001;
            r_adr <= w_issueAdr;
            r_dat <= w_issueDat;
        end
    end

    // Wait counter counts strobe cycles that saw no acknowledge; bus_err is
    // sticky so software can tell that at least one access was fabricated.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_waitCnt <= 8'd0;
            r_busErr  <= 1'b0;
        end else begin
            if (w_done) begin
                r_waitCnt <= 8'd0;
            end else if (r_stb) begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end
            if (w_timeout) begin
                r_busErr <= 1'b1;
            end
        end
    end

    // init_done rises on the edge after the last init write has completed,
    // i.e. the first edge seen outside the INIT state.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_initDone <= 1'b0;
        end else if (r_state != INIT) begin
            r_initDone <= 1'b1;
        end
    end

    // Single-entry TX buffer. Accepting a new byte wins over the clear from a
    // finished THR write so a byte accepted on that edge is never lost.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_txFull <= 1'b0;
            r_txData <= 8'h00;
        end else if (tx_valid && w_txReady) begin
            r_txFull <= 1'b1;
            r_txData <= tx_data;
        end else if (w_txClear) begin
            r_txFull <= 1'b0;
        end
    end

    // RX holding register. rx_ready only matters while a byte is waiting;
    // POLL never starts an RHR read while rx_valid is set, so a load and a
    // consume cannot collide.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_rxValid <= 1'b0;
            r_rxData  <= 8'h00;
        end else if (w_rxLoad) begin
            r_rxValid <= 1'b1;
            r_rxData  <= w_rdByte;
        end else if (r_rxValid && rx_ready) begin
            r_rxValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_host_ctrl
// Bench for uart_host_ctrl. A behavioural Wishbone slave returns a
// programmable LSR and RHR value and acknowledges one cycle after the strobe
// (or never, when acknowledges are disabled). Directed stimulus pushes the
// expected bus transactions and received bytes into queues; an independent
// monitor pops and compares them as the DUT presents them. LSR polls are
// not queued because their count depends on timing.
// ---------------------------------------------------------------------------
module tb_uart_host_ctrl;

    localparam logic [31:0] BASE = 32'h1250_0000;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [7:0]  dat;
    } txn_t;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       init_done;
    logic       bus_err;

    logic       ackEnable = 1'b1;
    logic [7:0] lsrVal = 8'h00;
    logic [7:0] rhrVal = 8'h00;

    int         checks = 0;
    int         errors = 0;

    txn_t       expQ[$];
    logic [7:0] rxQ[$];

    logic [2:0] initOfs [7] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1, 3'd4};
    logic [7:0] initDat [7] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00, 8'h03};

    uart_host_ctrl_if bus();

    uart_host_ctrl dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .wb        (bus),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .init_done (init_done),
        .bus_err   (bus_err)
    );

    // 100 MHz-style clock, period 10.
    always #5 CLK_I = ~CLK_I;

    // Slave acknowledge: one cycle after the strobe is seen, single-cycle
    // pulse, suppressed entirely while ackEnable is low.
    always @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            bus.ACK_I <= 1'b0;
        end else begin
            bus.ACK_I <= bus.STB_O & ~bus.ACK_I & ackEnable;
        end
    end

    // Slave read data decode: LSR at offset 5, RHR at offset 0.
    assign bus.DAT_I = (bus.ADR_O == BASE + 32'd5) ? {24'h000000, lsrVal} :
                       (bus.ADR_O == BASE)         ? {24'h000000, rhrVal} :
                                                     32'h0000_0000;

    // One comparison; every mismatch prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Set what the slave returns for LSR and RHR reads.
    task automatic applyStimulus(input logic [7:0] lsr, input logic [7:0] rhr);
        lsrVal = lsr;
        rhrVal = rhr;
    endtask

    task automatic pushTxn(input logic [2:0] ofs, input logic we, input logic [7:0] dat);
        txn_t e;
        e.adr = BASE + {29'd0, ofs};
        e.we  = we;
        e.dat = dat;
        expQ.push_back(e);
    endtask

    task automatic pushInitSequence();
        for (int i = 0; i < 7; i++) begin
            pushTxn(initOfs[i], 1'b1, initDat[i]);
        end
    endtask

    task automatic waitQueueEmpty(input string name, input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge CLK_I);
            n++;
        end
        checkOutput(name, expQ.size(), 0);
    endtask

    task automatic waitInitDone(input int budget);
        int n;
        n = 0;
        while (!init_done && n < budget) begin
            @(negedge CLK_I);
            n++;
        end
        checkOutput("init_done_rise", init_done, 1);
    endtask

    task automatic waitRxValid(input string name, input int budget);
        int n;
        n = 0;
        while (!rx_valid && n < budget) begin
            @(negedge CLK_I);
            n++;
        end
        checkOutput(name, rx_valid, 1);
    endtask

    // Offer a byte until the controller takes it, then drop tx_valid.
    task automatic sendByte(input logic [7:0] b, input int budget);
        int n;
        @(negedge CLK_I);
        tx_valid = 1'b1;
        tx_data  = b;
        n = 0;
        while (!tx_ready && n < budget) begin
            @(negedge CLK_I);
            n++;
        end
        checkOutput("tx_accept", tx_ready, 1);
        @(negedge CLK_I);
        tx_valid = 1'b0;
    endtask

    task automatic pulseRxReady();
        @(negedge CLK_I);
        rx_ready = 1'b1;
        @(negedge CLK_I);
        rx_ready = 1'b0;
    endtask

    // Monitor: compares each new non-poll bus transaction and each new
    // rx_valid presentation against the front of its queue.
    initial begin
        logic prevStb;
        logic prevRx;
        txn_t e;
        prevStb = 1'b0;
        prevRx  = 1'b0;
        forever begin
            @(negedge CLK_I);
            if (bus.STB_O && !prevStb) begin
                if (bus.ADR_O == BASE + 32'd5 && !bus.WE_O) begin
                    checkOutput("poll_sel", {28'd0, bus.SEL_O}, 32'h1);
                end else if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_txn: got adr %h we %b dat %h, expected none",
                             bus.ADR_O, bus.WE_O, bus.DAT_O);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("txn_adr", bus.ADR_O, e.adr);
                    checkOutput("txn_we", {31'd0, bus.WE_O}, {31'd0, e.we});
                    checkOutput("txn_sel", {28'd0, bus.SEL_O}, 32'h1);
                    if (e.we) begin
                        checkOutput("txn_dat", bus.DAT_O, {24'd0, e.dat});
                    end
                end
            end
            if (rx_valid && !prevRx) begin
                if (rxQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rx: got %h, expected none", rx_data);
                end else begin
                    checkOutput("rx_data", {24'd0, rx_data}, {24'd0, rxQ.pop_front()});
                end
            end
            prevStb = bus.STB_O;
            prevRx  = rx_valid;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int cnt;
        int n;

        #3 RST_I = 1'b0;
        @(negedge CLK_I);
        @(negedge CLK_I);
        checkOutput("rst_cyc_stb_we", {29'd0, bus.CYC_O, bus.STB_O, bus.WE_O}, 32'h0);
        checkOutput("rst_sel", {28'd0, bus.SEL_O}, 32'h0);
        checkOutput("rst_adr", bus.ADR_O, 32'h0);
        checkOutput("rst_dat", bus.DAT_O, 32'h0);
        checkOutput("rst_tx_ready", tx_ready, 0);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_rx_data", rx_data, 0);
        checkOutput("rst_init_done", init_done, 0);
        checkOutput("rst_bus_err", bus_err, 0);

        // Initialisation sequence after reset release.
        applyStimulus(8'h00, 8'h00);
        pushInitSequence();
        RST_I = 1'b1;
        waitInitDone(200);
        waitQueueEmpty("init_txns", 50);
        checkOutput("tx_ready_after_init", tx_ready, 1);
        checkOutput("bus_err_after_init", bus_err, 0);

        // Transmit one byte with THR empty.
        applyStimulus(8'h20, 8'h00);
        pushTxn(3'd0, 1'b1, 8'h41);
        sendByte(8'h41, 100);
        checkOutput("tx_ready_while_full", tx_ready, 0);
        waitQueueEmpty("thr_write", 100);
        n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge CLK_I);
            n++;
        end
        checkOutput("tx_ready_after_write", tx_ready, 1);

        // Receive with rx_ready held low; further data-ready polls must not
        // trigger another RHR read until the byte is consumed.
        pushTxn(3'd0, 1'b0, 8'h00);
        rxQ.push_back(8'h5A);
        applyStimulus(8'h01, 8'h5A);
        waitRxValid("rx_valid_first", 200);
        repeat (40) @(negedge CLK_I);
        checkOutput("rx_valid_held", rx_valid, 1);
        checkOutput("rx_data_held", rx_data, 8'h5A);
        applyStimulus(8'h01, 8'h33);
        pushTxn(3'd0, 1'b0, 8'h00);
        rxQ.push_back(8'h33);
        pulseRxReady();
        waitRxValid("rx_valid_second", 200);
        applyStimulus(8'h00, 8'h00);
        repeat (10) @(negedge CLK_I);
        pulseRxReady();
        checkOutput("rx_valid_consumed", rx_valid, 0);
        @(negedge CLK_I);
        rx_ready = 1'b1;
        repeat (5) @(negedge CLK_I);
        rx_ready = 1'b0;
        checkOutput("rx_ready_idle_no_effect", rx_valid, 0);

        // TX and RX both pending on the same LSR value: THR write goes first.
        pushTxn(3'd0, 1'b1, 8'h7E);
        pushTxn(3'd0, 1'b0, 8'h00);
        rxQ.push_back(8'hC3);
        sendByte(8'h7E, 100);
        checkOutput("tx_full_before_lsr", tx_ready, 0);
        applyStimulus(8'h21, 8'hC3);
        waitRxValid("rx_valid_priority", 300);
        waitQueueEmpty("priority_txns", 50);
        checkOutput("tx_ready_after_priority", tx_ready, 1);
        applyStimulus(8'h00, 8'h00);
        repeat (10) @(negedge CLK_I);
        pulseRxReady();

        // Slave stops acknowledging: the strobe must drop after TIMEOUT.
        n = 0;
        while (bus.STB_O && n < 100) begin
            @(negedge CLK_I);
            n++;
        end
        ackEnable = 1'b0;
        n = 0;
        while (!bus.STB_O && n < 20) begin
            @(negedge CLK_I);
            n++;
        end
        checkOutput("timeout_stb_start", bus.STB_O, 1);
        cnt = 0;
        while (bus.STB_O && cnt < 200) begin
            cnt++;
            @(negedge CLK_I);
        end
        checkOutput("timeout_stb_cycles", cnt, 64);
        checkOutput("timeout_cyc_low", bus.CYC_O, 0);
        checkOutput("timeout_bus_err", bus_err, 1);
        n = 0;
        while (!bus.STB_O && n < 20) begin
            @(negedge CLK_I);
            n++;
        end
        checkOutput("timeout_sequence_continues", bus.STB_O, 1);

        // Reset in the middle of a stalled transaction.
        repeat (3) @(negedge CLK_I);
        RST_I = 1'b0;
        #1;
        checkOutput("mid_rst_cyc", bus.CYC_O, 0);
        checkOutput("mid_rst_stb", bus.STB_O, 0);
        checkOutput("mid_rst_bus_err", bus_err, 0);
        checkOutput("mid_rst_init_done", init_done, 0);
        checkOutput("mid_rst_tx_ready", tx_ready, 0);
        ackEnable = 1'b1;
        pushInitSequence();
        @(negedge CLK_I);
        @(negedge CLK_I);
        RST_I = 1'b1;
        waitInitDone(200);
        waitQueueEmpty("reinit_txns", 50);
        checkOutput("bus_err_after_reinit", bus_err, 0);

        repeat (10) @(negedge CLK_I);
        checkOutput("rx_queue_drained", rxQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
